// File: rtl/mem_responder_pkg.sv
// Shared definitions for the MFA/MFC memory responder: op3 codes, FSM states
// and access-size encoding.
package mem_responder_pkg;

   localparam logic [5:0] OpLd   = 6'b000000;
   localparam logic [5:0] OpLdub = 6'b000001;
   localparam logic [5:0] OpLduh = 6'b000010;
   localparam logic [5:0] OpLdsb = 6'b001001;
   localparam logic [5:0] OpLdsh = 6'b001010;
   localparam logic [5:0] OpSt   = 6'b000100;
   localparam logic [5:0] OpStb  = 6'b000101;
   localparam logic [5:0] OpSth  = 6'b000110;

   localparam int unsigned CntW = 4;

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   typedef enum logic [1:0] {SizeByte, SizeHalf, SizeWord} size_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the datapath (master) and the memory responder (slave).
interface mem_responder_if #(
   parameter int unsigned ADDR_W = 8
) ();

   logic              MFA;
   logic [5:0]        opcode;
   logic [ADDR_W-1:0] address;
   logic [31:0]       DataIn;
   logic [31:0]       DataOut;
   logic              MFC;
   logic              MAE;

   modport master (
      output MFA, opcode, address, DataIn,
      input  DataOut, MFC, MAE
   );

   modport slave (
      input  MFA, opcode, address, DataIn,
      output DataOut, MFC, MAE
   );

endinterface

// File: rtl/mem_lane_align.sv
// Decodes an op3 opcode into access size, signedness and direction, and flags
// misaligned word/halfword addresses.
module mem_lane_align
   import mem_responder_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [1:0] addr_lo,
   output size_e      size,
   output logic       is_signed,
   output logic       is_load,
   output logic       is_store,
   output logic       misaligned
);

   always_comb begin
      size      = SizeWord;
      is_signed = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      case (opcode)
         OpLd:   begin is_load = 1'b1; size = SizeWord; end
         OpLdub: begin is_load = 1'b1; size = SizeByte; end
         OpLduh: begin is_load = 1'b1; size = SizeHalf; end
         OpLdsb: begin is_load = 1'b1; size = SizeByte; is_signed = 1'b1; end
         OpLdsh: begin is_load = 1'b1; size = SizeHalf; is_signed = 1'b1; end
         OpSt:   begin is_store = 1'b1; size = SizeWord; end
         OpStb:  begin is_store = 1'b1; size = SizeByte; end
         OpSth:  begin is_store = 1'b1; size = SizeHalf; end
         default: ;
      endcase
      // No-op opcodes never trap, whatever the address.
      misaligned = (is_load | is_store) &
                   (((size == SizeWord) & (addr_lo != 2'b00)) |
                    ((size == SizeHalf) & addr_lo[0]));
   end

endmodule

// File: rtl/mem_responder.sv
// Big-endian byte-addressed memory answering the MFA/MFC four-phase handshake,
// with a programmable number of wait states and misalignment reporting.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned WAIT_STATES = 2
) (
   input logic             Clk,
   input logic             Clr,
   mem_responder_if.slave  bus
);

   localparam int unsigned     Depth    = 2 ** ADDR_W;
   localparam logic [CntW-1:0] WaitInit = CntW'(WAIT_STATES);

   logic [7:0] mem [Depth];

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;
   logic [5:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       dout_q;
   logic              mfc_q;
   logic              mae_q;

   logic [5:0]        acc_op;
   logic [ADDR_W-1:0] acc_addr;
   logic [31:0]       acc_wdata;
   logic              capture;
   logic              fire;

   size_e size;
   logic  is_signed;
   logic  is_load;
   logic  is_store;
   logic  misaligned;

   logic [31:0] rd_word;
   logic [15:0] rd_half;
   logic [7:0]  rd_byte;
   logic [31:0] load_val;

   function automatic logic [31:0] extend_load(size_e sz, logic sgn, logic [7:0] b,
                                               logic [15:0] h, logic [31:0] w);
      logic [31:0] r;
      case (sz)
         SizeByte: r = {{24{sgn & b[7]}}, b};
         SizeHalf: r = {{16{sgn & h[15]}}, h};
         default:  r = w;
      endcase
      return r;
   endfunction

   // In IDLE the access is decoded straight from the bus so a zero-wait access
   // can complete on the capture edge; afterwards the latched copy is used.
   assign capture   = (state_q == StIdle) & bus.MFA;
   assign acc_op    = (state_q == StIdle) ? bus.opcode  : op_q;
   assign acc_addr  = (state_q == StIdle) ? bus.address : addr_q;
   assign acc_wdata = (state_q == StIdle) ? bus.DataIn  : wdata_q;

   mem_lane_align u_lane_align (
      .opcode     (acc_op),
      .addr_lo    (acc_addr[1:0]),
      .size       (size),
      .is_signed  (is_signed),
      .is_load    (is_load),
      .is_store   (is_store),
      .misaligned (misaligned)
   );

   assign fire = Clr &
                 ((capture & ~misaligned & (WaitInit == '0)) |
                  ((state_q == StWait) & (cnt_q == CntW'(1))));

   assign rd_word = {mem[{acc_addr[ADDR_W-1:2], 2'b00}], mem[{acc_addr[ADDR_W-1:2], 2'b01}],
                     mem[{acc_addr[ADDR_W-1:2], 2'b10}], mem[{acc_addr[ADDR_W-1:2], 2'b11}]};
   assign rd_half = acc_addr[1] ? rd_word[15:0] : rd_word[31:16];

   always_comb begin
      rd_byte = rd_word[31:24];
      unique case (acc_addr[1:0])
         2'b00: rd_byte = rd_word[31:24];
         2'b01: rd_byte = rd_word[23:16];
         2'b10: rd_byte = rd_word[15:8];
         2'b11: rd_byte = rd_word[7:0];
      endcase
   end

   assign load_val = extend_load(size, is_signed, rd_byte, rd_half, rd_word);

   // Storage is deliberately outside the reset domain so its contents survive Clr.
   always_ff @(posedge Clk) begin
      if (fire && is_store) begin
         case (size)
            SizeByte: mem[acc_addr] <= acc_wdata[7:0];
            SizeHalf: begin
               mem[{acc_addr[ADDR_W-1:1], 1'b0}] <= acc_wdata[15:8];
               mem[{acc_addr[ADDR_W-1:1], 1'b1}] <= acc_wdata[7:0];
            end
            SizeWord: begin
               mem[{acc_addr[ADDR_W-1:2], 2'b00}] <= acc_wdata[31:24];
               mem[{acc_addr[ADDR_W-1:2], 2'b01}] <= acc_wdata[23:16];
               mem[{acc_addr[ADDR_W-1:2], 2'b10}] <= acc_wdata[15:8];
               mem[{acc_addr[ADDR_W-1:2], 2'b11}] <= acc_wdata[7:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         dout_q  <= '0;
         mfc_q   <= 1'b0;
         mae_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.MFA) begin
                  op_q    <= bus.opcode;
                  addr_q  <= bus.address;
                  wdata_q <= bus.DataIn;
                  cnt_q   <= WaitInit;
                  if (misaligned) begin
                     state_q <= StDone;
                     mfc_q   <= 1'b1;
                     mae_q   <= 1'b1;
                  end else if (WaitInit == '0) begin
                     state_q <= StDone;
                     mfc_q   <= 1'b1;
                     if (is_load) dout_q <= load_val;
                  end else begin
                     state_q <= StWait;
                  end
               end
            end
            StWait: begin
               cnt_q <= cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) begin
                  state_q <= StDone;
                  mfc_q   <= 1'b1;
                  if (is_load) dout_q <= load_val;
               end
            end
            StDone: begin
               if (!bus.MFA) begin
                  state_q <= StIdle;
                  mfc_q   <= 1'b0;
                  mae_q   <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.DataOut = dout_q;
   assign bus.MFC     = mfc_q;
   assign bus.MAE     = mae_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a 2-wait-state instance carries most scenarios,
// a zero-wait instance covers single-edge completion.
module tb_mem_responder;
   import mem_responder_pkg::*;

   logic Clk;
   logic Clr;
   int   total;
   int   bad;

   mem_responder_if #(.ADDR_W(8)) bus ();
   mem_responder_if #(.ADDR_W(8)) bus0 ();

   mem_responder #(.ADDR_W(8), .WAIT_STATES(2)) u_dut (
      .Clk (Clk),
      .Clr (Clr),
      .bus (bus)
   );

   mem_responder #(.ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
      .Clk (Clk),
      .Clr (Clr),
      .bus (bus0)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Raise MFA with the given request; edges = rising edges until MFC seen (0 = timeout).
   task automatic request(input logic [5:0] op, input logic [7:0] addr, input logic [31:0] data,
                          output int edges);
      @(negedge Clk);
      bus.MFA = 1'b1; bus.opcode = op; bus.address = addr; bus.DataIn = data;
      edges = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge Clk); #1;
         if (bus.MFC) begin
            edges = i;
            break;
         end
      end
   endtask

   task automatic release_req();
      @(negedge Clk);
      bus.MFA = 1'b0;
      @(posedge Clk); #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge Clk);
      #1;
      total++; if (bus.MFC !== 1'b0) begin bad++; $display("FAIL reset_mfc: got %b want 0", bus.MFC); end
      total++; if (bus.MAE !== 1'b0) begin bad++; $display("FAIL reset_mae: got %b want 0", bus.MAE); end
      total++; if (bus.DataOut !== 32'h0) begin
         bad++; $display("FAIL reset_dout: got %h want 00000000", bus.DataOut);
      end
      @(negedge Clk);
      Clr = 1'b1;
   endtask

   task automatic test_preload();
      int e;
      request(OpSt, 8'h00, 32'h9C044012, e);
      total++; if (e != 3) begin bad++; $display("FAIL st_latency: got %0d want 3", e); end
      release_req();
      total++; if (bus.MFC !== 1'b0) begin bad++; $display("FAIL st_release: got %b want 0", bus.MFC); end
   endtask

   task automatic test_ld();
      int e;
      request(OpLd, 8'h00, 32'h0, e);
      total++; if (e != 3) begin bad++; $display("FAIL ld_latency: got %0d want 3", e); end
      total++; if (bus.DataOut !== 32'h9C044012) begin
         bad++; $display("FAIL ld_data: got %h want 9c044012", bus.DataOut);
      end
      total++; if (bus.MAE !== 1'b0) begin bad++; $display("FAIL ld_mae: got %b want 0", bus.MAE); end
      release_req();
      total++; if (bus.MFC !== 1'b0) begin bad++; $display("FAIL ld_release: got %b want 0", bus.MFC); end
   endtask

   task automatic test_extend();
      logic [5:0]  ops  [5] = '{OpLdsb, OpLdub, OpLdsh, OpLduh, OpLdsh};
      logic [7:0]  adrs [5] = '{8'h00, 8'h00, 8'h02, 8'h00, 8'h00};
      logic [31:0] exps [5] = '{32'hFFFFFF9C, 32'h0000009C, 32'h00004012, 32'h00009C04,
                                32'hFFFF9C04};
      int e;
      for (int i = 0; i < 5; i++) begin
         request(ops[i], adrs[i], 32'h0, e);
         total++; if (bus.DataOut !== exps[i] || e != 3) begin
            bad++; $display("FAIL extend_%0d: got %h after %0d edges want %h after 3",
                            i, bus.DataOut, e, exps[i]);
         end
         release_req();
      end
   endtask

   task automatic test_store_lanes();
      int e;
      request(OpSth, 8'h02, 32'h1234ABCD, e); release_req();
      request(OpLd, 8'h00, 32'h0, e);
      total++; if (bus.DataOut !== 32'h9C04ABCD) begin
         bad++; $display("FAIL sth_lane: got %h want 9c04abcd", bus.DataOut);
      end
      release_req();
      request(OpStb, 8'h01, 32'h000000EE, e); release_req();
      request(OpLd, 8'h00, 32'h0, e);
      total++; if (bus.DataOut !== 32'h9CEEABCD) begin
         bad++; $display("FAIL stb_lane: got %h want 9ceeabcd", bus.DataOut);
      end
      release_req();
   endtask

   task automatic test_misaligned();
      int e;
      request(OpLduh, 8'h01, 32'h0, e);
      total++; if (e != 1 || bus.MAE !== 1'b1) begin
         bad++; $display("FAIL mis_lduh: got edges=%0d mae=%b want edges=1 mae=1", e, bus.MAE);
      end
      total++; if (bus.DataOut !== 32'h9CEEABCD) begin
         bad++; $display("FAIL mis_dout: got %h want 9ceeabcd", bus.DataOut);
      end
      release_req();
      total++; if (bus.MAE !== 1'b0 || bus.MFC !== 1'b0) begin
         bad++; $display("FAIL mis_clear: got mae=%b mfc=%b want 0 0", bus.MAE, bus.MFC);
      end
      request(OpSt, 8'h02, 32'hFFFFFFFF, e);
      total++; if (e != 1 || bus.MAE !== 1'b1) begin
         bad++; $display("FAIL mis_st: got edges=%0d mae=%b want edges=1 mae=1", e, bus.MAE);
      end
      release_req();
      request(OpLd, 8'h00, 32'h0, e);
      total++; if (bus.DataOut !== 32'h9CEEABCD) begin
         bad++; $display("FAIL mis_nowrite: got %h want 9ceeabcd", bus.DataOut);
      end
      release_req();
   endtask

   task automatic test_abort();
      int e;
      request(OpSt, 8'h10, 32'h11223344, e); release_req();
      @(negedge Clk);
      bus.MFA = 1'b1; bus.opcode = OpSt; bus.address = 8'h10; bus.DataIn = 32'hDEADBEEF;
      @(posedge Clk); #3;
      Clr = 1'b0;
      #1;
      total++; if (bus.MFC !== 1'b0 || bus.DataOut !== 32'h0) begin
         bad++; $display("FAIL abort_reset: got mfc=%b dout=%h want 0 00000000", bus.MFC,
                         bus.DataOut);
      end
      @(negedge Clk);
      bus.MFA = 1'b0;
      Clr = 1'b1;
      repeat (4) @(posedge Clk);
      request(OpLd, 8'h10, 32'h0, e);
      total++; if (bus.DataOut !== 32'h11223344) begin
         bad++; $display("FAIL abort_nowrite: got %h want 11223344", bus.DataOut);
      end
      release_req();
   endtask

   task automatic test_noop();
      int e;
      request(OpLd, 8'h00, 32'h0, e); release_req();
      request(6'b111111, 8'h10, 32'h55555555, e);
      total++; if (e != 3 || bus.MAE !== 1'b0 || bus.DataOut !== 32'h9CEEABCD) begin
         bad++; $display("FAIL noop: got edges=%0d mae=%b dout=%h want 3 0 9ceeabcd", e, bus.MAE,
                         bus.DataOut);
      end
      release_req();
      request(OpLd, 8'h10, 32'h0, e);
      total++; if (bus.DataOut !== 32'h11223344) begin
         bad++; $display("FAIL noop_mem: got %h want 11223344", bus.DataOut);
      end
      release_req();
   endtask

   task automatic test_hold();
      int e;
      int drops;
      request(OpSt, 8'h20, 32'hCAFEF00D, e);
      total++; if (e != 3) begin bad++; $display("FAIL hold_latency: got %0d want 3", e); end
      @(negedge Clk);
      bus.opcode = OpStb; bus.address = 8'h20; bus.DataIn = 32'h0;
      drops = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge Clk); #1;
         if (bus.MFC !== 1'b1) drops++;
      end
      total++; if (drops != 0) begin bad++; $display("FAIL hold_mfc: got %0d drops want 0", drops); end
      release_req();
      request(OpLd, 8'h20, 32'h0, e);
      total++; if (bus.DataOut !== 32'hCAFEF00D) begin
         bad++; $display("FAIL hold_single: got %h want cafef00d", bus.DataOut);
      end
      release_req();
   endtask

   task automatic test_drop_in_wait();
      int e;
      int highs;
      @(negedge Clk);
      bus.MFA = 1'b1; bus.opcode = OpStb; bus.address = 8'h21; bus.DataIn = 32'h0000005A;
      @(negedge Clk);
      bus.MFA = 1'b0;
      highs = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge Clk); #1;
         if (bus.MFC === 1'b1) highs++;
      end
      total++; if (highs != 1) begin bad++; $display("FAIL drop_pulse: got %0d cycles want 1", highs); end
      request(OpLd, 8'h20, 32'h0, e);
      total++; if (bus.DataOut !== 32'hCA5AF00D) begin
         bad++; $display("FAIL drop_store: got %h want ca5af00d", bus.DataOut);
      end
      release_req();
   endtask

   task automatic test_zero_wait();
      @(negedge Clk);
      bus0.MFA = 1'b1; bus0.opcode = OpSt; bus0.address = 8'h04; bus0.DataIn = 32'hA1B2C3D4;
      @(posedge Clk); #1;
      total++; if (bus0.MFC !== 1'b1) begin bad++; $display("FAIL zw_st_mfc: got %b want 1", bus0.MFC); end
      @(negedge Clk); bus0.MFA = 1'b0;
      @(negedge Clk);
      bus0.MFA = 1'b1; bus0.opcode = OpLd; bus0.address = 8'h04;
      @(posedge Clk); #1;
      total++; if (bus0.MFC !== 1'b1 || bus0.DataOut !== 32'hA1B2C3D4) begin
         bad++; $display("FAIL zw_ld: got mfc=%b dout=%h want 1 a1b2c3d4", bus0.MFC, bus0.DataOut);
      end
      @(negedge Clk); bus0.MFA = 1'b0;
      @(posedge Clk); #1;
      total++; if (bus0.MFC !== 1'b0) begin bad++; $display("FAIL zw_release: got %b want 0", bus0.MFC); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      total = 0;
      bad   = 0;
      Clr   = 1'b0;
      bus.MFA = 1'b0; bus.opcode = '0; bus.address = '0; bus.DataIn = '0;
      bus0.MFA = 1'b0; bus0.opcode = '0; bus0.address = '0; bus0.DataIn = '0;
      test_reset();
      test_preload();
      test_ld();
      test_extend();
      test_store_lanes();
      test_misaligned();
      test_abort();
      test_noop();
      test_hold();
      test_drop_in_wait();
      test_zero_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
